// File: rtl/level_classifier.sv
// BCD sample to binary integer conversion, followed by level classification
// with downward hysteresis, a persistence filter and a switchable alarm level.
//
// state    | meaning
// IDLE     | waiting for a sample
// CONV     | one BCD nibble folded into the accumulator per cycle, MSD first
// CLASSIFY | done pulse; int_value/err/level registers updated at the closing edge
module level_classifier #(
  parameter int DIGITS    = 8,
  parameter int STABLE_N  = 2,
  parameter int HYST      = 1,
  parameter int THR1      = 6,
  parameter int THR2      = 8,
  parameter int THR3      = 10,
  parameter int THR4      = 12,
  parameter int THR5      = 13,
  parameter int THR6      = 14,
  parameter int ALARM_THR = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   number,
  input  logic [DIGITS-1:0]     dp_list,
  input  logic                  sample_valid,
  input  logic                  mode_toggle,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           int_value,
  output logic                  err,
  output logic [2:0]            state,
  output logic                  alarm,
  output logic                  mode
);

  localparam int UW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CONV, CLASSIFY} fsm_t;

  fsm_t                st_q, st_d;
  logic [4*DIGITS-1:0] num_q, num_d;
  logic [UW-1:0]       dig_q, dig_d, unit_q, unit_d, unit_in;
  logic [31:0]         acc_q, acc_d, int_value_q, int_value_d;
  logic                acc_err_q, acc_err_d, err_q, err_d, mode_q, mode_d;
  logic [2:0]          state_q, state_d, pending_q, pending_d;
  logic [3:0]          cnt_q, cnt_d;

  logic [3:0]          nib, nib_val;
  logic                nib_bad;
  logic [2:0]          raw, cand, pend_nx;
  logic [3:0]          cnt_nx;

  // Lower bound of each level; level 7 only exists above ALARM_THR.
  function automatic logic [31:0] thr_of(input int n);
    case (n)
      1:       return 32'(THR1);
      2:       return 32'(THR2);
      3:       return 32'(THR3);
      4:       return 32'(THR4);
      5:       return 32'(THR5);
      6:       return 32'(THR6);
      7:       return 32'(ALARM_THR + 1);
      default: return 32'd0;
    endcase
  endfunction

  always_comb begin
    unit_in = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (dp_list[k]) unit_in = UW'(k);
    end
  end

  // The captured word is shifted left so the digit being processed is always on top.
  assign nib     = num_q[4*DIGITS-1 -: 4];
  assign nib_bad = (nib >= 4'hA) && (nib <= 4'hE);
  assign nib_val = (nib <= 4'h9) ? nib : 4'h0;

  always_comb begin
    raw = '0;
    for (int i = 1; i <= 6; i++) begin
      if (acc_q >= thr_of(i)) raw = raw + 3'd1;
    end
    if (mode_q && (acc_q > 32'(ALARM_THR))) raw = 3'd7;
  end

  always_comb begin
    cand = raw;
    if ((raw < state_q) && !((state_q == 3'd7) && !mode_q) &&
        (acc_q + 32'(HYST) >= thr_of(int'(state_q))))
      cand = state_q;
  end

  always_comb begin
    st_d        = st_q;
    num_d       = num_q;
    dig_d       = dig_q;
    unit_d      = unit_q;
    acc_d       = acc_q;
    acc_err_d   = acc_err_q;
    int_value_d = int_value_q;
    err_d       = err_q;
    state_d     = state_q;
    pending_d   = pending_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q ^ mode_toggle;
    pend_nx     = pending_q;
    cnt_nx      = cnt_q;

    case (st_q)
      CONV: begin
        acc_err_d = acc_err_q | nib_bad;
        if (dig_q >= unit_q) acc_d = acc_q * 32'd10 + 32'(nib_val);
        num_d = num_q << 4;
        if (dig_q == '0) st_d = CLASSIFY;
        else             dig_d = dig_q - 1'b1;
      end
      CLASSIFY: begin
        int_value_d = acc_q;
        err_d       = acc_err_q;
        st_d        = IDLE;
        if (!acc_err_q) begin
          if (cand == state_q) begin
            cnt_d = '0;
          end else begin
            if (cand == pending_q) begin
              cnt_nx = cnt_q + 4'd1;
            end else begin
              pend_nx = cand;
              cnt_nx  = 4'd1;
            end
            pending_d = pend_nx;
            if (cnt_nx == 4'(STABLE_N)) begin
              state_d = pend_nx;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_nx;
            end
          end
        end
      end
      default: ;
    endcase

    // A new sample can be taken in CLASSIFY; the level update above still uses acc_q.
    if (sample_valid && (st_q != CONV)) begin
      st_d      = CONV;
      num_d     = number;
      unit_d    = unit_in;
      dig_d     = UW'(DIGITS - 1);
      acc_d     = '0;
      acc_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= IDLE;
      num_q       <= '0;
      dig_q       <= '0;
      unit_q      <= '0;
      acc_q       <= '0;
      acc_err_q   <= 1'b0;
      int_value_q <= '0;
      err_q       <= 1'b0;
      state_q     <= '0;
      pending_q   <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
    end else begin
      st_q        <= st_d;
      num_q       <= num_d;
      dig_q       <= dig_d;
      unit_q      <= unit_d;
      acc_q       <= acc_d;
      acc_err_q   <= acc_err_d;
      int_value_q <= int_value_d;
      err_q       <= err_d;
      state_q     <= state_d;
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
    end
  end

  assign busy      = (st_q == CONV);
  assign done      = (st_q == CLASSIFY);
  assign int_value = int_value_q;
  assign err       = err_q;
  assign state     = state_q;
  assign alarm     = (state_q == 3'd7);
  assign mode      = mode_q;

endmodule

// File: tb/tb_level_classifier.sv
// Scenario bench for level_classifier: expected results are queued when a
// sample is driven and compared by a monitor one edge after each done pulse.
module tb_level_classifier;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] number;
  logic [7:0]  dp_list;
  logic        sample_valid;
  logic        mode_toggle;
  logic        busy, done, err, alarm, mode;
  logic [31:0] int_value;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] iv;
    logic        e;
    logic [2:0]  st;
  } exp_t;
  exp_t sb[$];

  level_classifier dut (
    .clk(clk), .rst(rst), .number(number), .dp_list(dp_list),
    .sample_valid(sample_valid), .mode_toggle(mode_toggle),
    .busy(busy), .done(done), .int_value(int_value), .err(err),
    .state(state), .alarm(alarm), .mode(mode)
  );

  always #5 clk = ~clk;

  // Results land at the edge that closes the done cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got done=1 required no pending sample");
        end else begin
          e = sb.pop_front();
          if (int_value !== e.iv) begin
            errors++;
            $display("FAIL sb_int_value: got %0d required %0d", int_value, e.iv);
          end
          checks++;
          if (err !== e.e) begin
            errors++;
            $display("FAIL sb_err: got %b required %b", err, e.e);
          end
          checks++;
          if (state !== e.st) begin
            errors++;
            $display("FAIL sb_state: got %b required %b", state, e.st);
          end
          checks++;
          if (alarm !== (e.st == 3'd7)) begin
            errors++;
            $display("FAIL sb_alarm: got %b required %b", alarm, (e.st == 3'd7));
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] num, input logic [7:0] dp,
                      input logic [31:0] iv, input logic e, input logic [2:0] st,
                      input bit tog_at_done = 1'b0);
    exp_t x;
    int   c;
    x.iv = iv; x.e = e; x.st = st;
    @(negedge clk);
    number = num; dp_list = dp; sample_valid = 1'b1;
    sb.push_back(x);
    @(posedge clk);
    #1 sample_valid = 1'b0;
    c = 0;
    while (c < 20) begin
      @(negedge clk);
      c++;
      if (done === 1'b1) break;
    end
    checks++;
    if (c != 9) begin
      errors++;
      $display("FAIL latency: got %0d cycles required 9", c);
    end
    if (tog_at_done) mode_toggle = 1'b1;
    @(posedge clk);
    #2 mode_toggle = 1'b0;
  endtask

  task automatic pulse_toggle();
    @(negedge clk);
    mode_toggle = 1'b1;
    @(posedge clk);
    #1 mode_toggle = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; number = '0; dp_list = '0; sample_valid = 1'b0; mode_toggle = 1'b0;
    #12;
    checks++;
    if ({busy, done, err, alarm, mode, state} !== 8'h00 || int_value !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b alarm=%b mode=%b state=%b iv=%0d required all 0",
               busy, done, err, alarm, mode, state, int_value);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_integer();
    send(32'hFFFFFF09, 8'h00, 32'd9, 1'b0, 3'b000);
    send(32'hFFFFFF09, 8'h00, 32'd9, 1'b0, 3'b010);
  endtask

  task automatic test_fractional();
    send(32'hFFFFF125, 8'h02, 32'd12, 1'b0, 3'b010);
    send(32'hFFFFF125, 8'h02, 32'd12, 1'b0, 3'b100);
  endtask

  task automatic test_hysteresis();
    send(32'hFFFFFF11, 8'h00, 32'd11, 1'b0, 3'b100);
    send(32'hFFFFFF11, 8'h00, 32'd11, 1'b0, 3'b100);
    send(32'hFFFFFF10, 8'h00, 32'd10, 1'b0, 3'b100);
    send(32'hFFFFFF10, 8'h00, 32'd10, 1'b0, 3'b011);
  endtask

  task automatic test_alarm();
    pulse_toggle();
    checks++;
    if (mode !== 1'b1) begin
      errors++;
      $display("FAIL mode_on: got %b required 1", mode);
    end
    send(32'hFFFFFF15, 8'h00, 32'd15, 1'b0, 3'b011);
    send(32'hFFFFFF15, 8'h00, 32'd15, 1'b0, 3'b111);
    pulse_toggle();
    checks++;
    if (mode !== 1'b0) begin
      errors++;
      $display("FAIL mode_off: got %b required 0", mode);
    end
    send(32'hFFFFFF15, 8'h00, 32'd15, 1'b0, 3'b111);
    send(32'hFFFFFF15, 8'h00, 32'd15, 1'b0, 3'b110);
  endtask

  task automatic test_toggle_at_classify();
    send(32'hFFFFFF15, 8'h00, 32'd15, 1'b0, 3'b110, 1'b1);
    checks++;
    if (mode !== 1'b1) begin
      errors++;
      $display("FAIL mode_coincident: got %b required 1", mode);
    end
    send(32'hFFFFFF15, 8'h00, 32'd15, 1'b0, 3'b110);
    send(32'hFFFFFF15, 8'h00, 32'd15, 1'b0, 3'b111);
  endtask

  task automatic test_err();
    send(32'hFFFFFA12, 8'h00, 32'd12, 1'b1, 3'b111);
    send(32'hFFFFFF15, 8'h00, 32'd15, 1'b0, 3'b111);
  endtask

  task automatic test_busy_ignore();
    exp_t x;
    int   n_done;
    x.iv = 32'd9; x.e = 1'b0; x.st = 3'b111;
    @(negedge clk);
    number = 32'hFFFFFF09; dp_list = 8'h00; sample_valid = 1'b1;
    sb.push_back(x);
    @(posedge clk);
    #1 sample_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_accept: got %b required 1", busy);
    end
    number = 32'hFFFFFF13; sample_valid = 1'b1;
    repeat (3) @(negedge clk);
    sample_valid = 1'b0;
    n_done = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    checks++;
    if (n_done != 1) begin
      errors++;
      $display("FAIL done_count: got %0d required 1", n_done);
    end
  endtask

  task automatic test_reset_in_conv();
    int n_done;
    @(negedge clk);
    number = 32'hFFFFFF09; dp_list = 8'h00; sample_valid = 1'b1;
    @(posedge clk);
    #1 sample_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, err, alarm, mode, state} !== 8'h00 || int_value !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_conv: got busy=%b done=%b err=%b alarm=%b mode=%b state=%b iv=%0d required all 0",
               busy, done, err, alarm, mode, state, int_value);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    checks++;
    if (n_done != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: got done_count=%0d busy=%b required 0 and 0", n_done, busy);
    end
    send(32'hFFFFFF12, 8'h00, 32'd12, 1'b0, 3'b000);
    send(32'hFFFFFF12, 8'h00, 32'd12, 1'b0, 3'b100);
  endtask

  initial begin
    test_reset();
    test_integer();
    test_fractional();
    test_hysteresis();
    test_alarm();
    test_toggle_at_classify();
    test_err();
    test_busy_ignore();
    test_reset_in_conv();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d outstanding required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
